openram_march_bist: RTL

//  Built-in self-test sequencer for the testchip SRAM macros. Runs a March C- test on port 0 of one

---
 rtl/openram_march_bist.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/openram_march_bist.sv
// March C- built-in self-test sequencer for port 0 of one OpenRAM macro.
// Issues one SRAM operation per cycle and compares read data through a
// 1-deep pipeline. Reports pass/fail, a saturating mismatch count and the
// first failing address/element.
module openram_march_bist #(
   parameter int ADDR_SIZE   = 8,
   parameter int DATA_SIZE   = 32,
   parameter int WMASK_SIZE  = 4,
   parameter int SELECT_SIZE = 4,
   parameter int MAX_CHIPS   = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic                   abort,
   input  logic [SELECT_SIZE-1:0] chip_sel,
   input  logic [ADDR_SIZE-1:0]   addr_max,
   input  logic [DATA_SIZE-1:0]   pattern,
   input  logic [DATA_SIZE-1:0]   sram_dout,
   output logic [SELECT_SIZE-1:0] sel_o,
   output logic [ADDR_SIZE-1:0]   addr0,
   output logic [DATA_SIZE-1:0]   din0,
   output logic                   web0,
   output logic [WMASK_SIZE-1:0]  wmask0,
   output logic [MAX_CHIPS-1:0]   csb0,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [7:0]             fail_count,
   output logic [ADDR_SIZE-1:0]   fail_addr,
   output logic [2:0]             fail_elem
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Element index 0..5 is M0..M5; 6 means every op has been issued.
   localparam logic [2:0]           ELEM_END = 3'd6;
   localparam logic [MAX_CHIPS-1:0] CHIP_ONE = MAX_CHIPS'(1);

   state_t                 state_q, state_d;

   // Latched test configuration
   logic [ADDR_SIZE-1:0]   addr_max_q;
   logic [DATA_SIZE-1:0]   pattern_q;

   // March position: element, address, op within the element
   logic [2:0]             elem_q, elem_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic                   phase_q, phase_d;

   // Op to register onto the SRAM bus this cycle
   logic                   issue;
   logic                   issue_we;
   logic [DATA_SIZE-1:0]   issue_data;
   logic                   start_accept;

   // Compare pipeline for the read issued on the previous edge
   logic                   cmp_valid;
   logic [DATA_SIZE-1:0]   cmp_exp;
   logic [ADDR_SIZE-1:0]   cmp_addr;
   logic [2:0]             cmp_elem;

   // Every issued write covers the full word.
   assign wmask0 = '1;

   assign start_accept = start && !abort && (state_q == S_IDLE || state_q == S_DONE);

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state, op selection and march counter advance
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      elem_d     = elem_q;
      addr_d     = addr_q;
      phase_d    = phase_q;
      issue      = 1'b0;
      issue_we   = 1'b0;
      issue_data = pattern_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               elem_d  = 3'd0;
               addr_d  = '0;
               phase_d = 1'b0;
            end
         end

         S_RUN: begin
            if (elem_q == ELEM_END) begin
               state_d = S_FLUSH;
            end else begin
               issue = 1'b1;
               if (!phase_q) begin
                  // First op of the element: M0 writes "0", others read.
                  issue_we   = (elem_q == 3'd0);
                  issue_data = (elem_q == 3'd2 || elem_q == 3'd4) ? ~pattern_q : pattern_q;
               end else begin
                  // Second op is always a write of the complement of the read value.
                  issue_we   = 1'b1;
                  issue_data = (elem_q == 3'd1 || elem_q == 3'd3) ? ~pattern_q : pattern_q;
               end

               if (!phase_q && elem_q != 3'd0 && elem_q != 3'd5) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (elem_q == 3'd3 || elem_q == 3'd4) begin
                     // Descending element: stop at address 0.
                     if (addr_q == '0) begin
                        elem_d = elem_q + 3'd1;
                        addr_d = (elem_q == 3'd3) ? addr_max_q : '0;
                     end else begin
                        addr_d = addr_q - ADDR_SIZE'(1);
                     end
                  end else begin
                     // Ascending element: stop at addr_max.
                     if (addr_q == addr_max_q) begin
                        elem_d = elem_q + 3'd1;
                        addr_d = (elem_q == 3'd2) ? addr_max_q : '0;
                     end else begin
                        addr_d = addr_q + ADDR_SIZE'(1);
                     end
                  end
               end
            end
         end

         S_FLUSH: state_d = S_DONE;

         default: state_d = S_IDLE;
      endcase

      if (abort) state_d = S_IDLE;
   end

   // March counters and latched configuration
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         elem_q     <= 3'd0;
         addr_q     <= '0;
         phase_q    <= 1'b0;
         addr_max_q <= '0;
         pattern_q  <= '0;
         sel_o      <= '0;
      end else begin
         elem_q  <= elem_d;
         addr_q  <= addr_d;
         phase_q <= phase_d;
         if (start_accept) begin
            addr_max_q <= addr_max;
            pattern_q  <= pattern;
            sel_o      <= chip_sel;
         end
      end
   end

   // SRAM port-0 bus: one registered op per cycle, idle otherwise
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         csb0  <= '1;
         web0  <= 1'b1;
         addr0 <= '0;
         din0  <= '0;
      end else if (abort || !issue) begin
         csb0 <= '1;
         web0 <= 1'b1;
      end else begin
         csb0  <= ~(CHIP_ONE << sel_o);
         web0  <= ~issue_we;
         addr0 <= addr_q;
         din0  <= issue_data;
      end
   end

   // Read-compare pipeline and result reporting
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cmp_valid  <= 1'b0;
         cmp_exp    <= '0;
         cmp_addr   <= '0;
         cmp_elem   <= 3'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_count <= 8'd0;
         fail_addr  <= '0;
         fail_elem  <= 3'd0;
      end else if (abort) begin
         // Abandon the test; the failure record so far is kept.
         cmp_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         cmp_valid <= issue && !issue_we;
         cmp_exp   <= issue_data;
         cmp_addr  <= addr_q;
         cmp_elem  <= elem_q;

         if (cmp_valid && sram_dout != cmp_exp) begin
            if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            if (fail_count == 8'd0) begin
               fail_addr <= cmp_addr;
               fail_elem <= cmp_elem;
            end
         end

         if (start_accept) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= 8'd0;
            fail_addr  <= '0;
            fail_elem  <= 3'd0;
         end

         if (state_q == S_FLUSH) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (fail_count == 8'd0);
         end
      end
   end

endmodule
